// File: rtl/accum_act_wb.sv
// Accumulator write-back: reads psum rows, requantizes them (shift, saturate) and writes them to the output memory.
// Optional ReLU after saturation is enabled by defining ACCUM_ACT_RELU_EN.
module accum_act_wb #(
    parameter int SYS_COL     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [DATA_WIDTH-1:0]            num_row,
    input  logic [ADDR_WIDTH-1:0]            accum_base_addr,
    input  logic [ADDR_WIDTH-1:0]            out_base_addr,
    input  logic [SHIFT_WIDTH-1:0]           shift,
    output logic [SYS_COL-1:0]               accum_rd_en,
    output logic [SYS_COL*ADDR_WIDTH-1:0]    accum_rd_addr,
    input  logic [SYS_COL*2*DATA_WIDTH-1:0]  accum_rd_data,
    output logic [SYS_COL-1:0]               out_wr_en,
    output logic [SYS_COL*ADDR_WIDTH-1:0]    out_wr_addr,
    output logic [SYS_COL*DATA_WIDTH-1:0]    out_wr_data,
    output logic                             busy,
    output logic                             done
);

    localparam int PSUM_W = 2 * DATA_WIDTH;
    localparam logic signed [PSUM_W-1:0] SAT_MAX =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  num_row_reg;
    logic [DATA_WIDTH-1:0]  row_cnt_reg;
    logic [ADDR_WIDTH-1:0]  rd_addr_reg;
    logic [ADDR_WIDTH-1:0]  out_base_reg;
    logic [SHIFT_WIDTH-1:0] shift_reg;
    logic                   rd_en_reg;
    logic                   rd_valid_reg;
    logic [ADDR_WIDTH-1:0]  rd_row_reg;
    logic                   wr_en_reg;
    logic [ADDR_WIDTH-1:0]  wr_addr_reg;
    logic                   busy_reg;
    logic                   done_reg;

    // Arithmetic shift floors toward -inf; saturation clips to the signed output range.
    function automatic logic [DATA_WIDTH-1:0] requant(
        input logic [PSUM_W-1:0]      psum,
        input logic [SHIFT_WIDTH-1:0] sh
    );
        logic signed [PSUM_W-1:0] shifted;
        logic [DATA_WIDTH-1:0]    sat;
        shifted = $signed(psum) >>> sh;
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DATA_WIDTH-1:0];
        else
            sat = shifted[DATA_WIDTH-1:0];
`ifdef ACCUM_ACT_RELU_EN
        if (sat[DATA_WIDTH-1])
            sat = '0;
`endif
        return sat;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            num_row_reg  <= '0;
            row_cnt_reg  <= '0;
            rd_addr_reg  <= '0;
            out_base_reg <= '0;
            shift_reg    <= '0;
            rd_en_reg    <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_row_reg   <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // Read data arrives one cycle after the read; the write follows one cycle later.
            rd_valid_reg <= rd_en_reg;
            rd_row_reg   <= row_cnt_reg[ADDR_WIDTH-1:0];
            wr_en_reg    <= rd_valid_reg;
            wr_addr_reg  <= out_base_reg + rd_row_reg;

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        num_row_reg  <= num_row;
                        out_base_reg <= out_base_addr;
                        shift_reg    <= shift;
                        row_cnt_reg  <= '0;
                        rd_addr_reg  <= accum_base_addr;
                        if (num_row == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_READ;
                            rd_en_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (row_cnt_reg == num_row_reg - DATA_WIDTH'(1)) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= S_DRAIN;
                    end else begin
                        row_cnt_reg <= row_cnt_reg + DATA_WIDTH'(1);
                        rd_addr_reg <= rd_addr_reg + ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // Last row is being written when the write stage is active but nothing follows it.
                    if (wr_en_reg && !rd_valid_reg) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < SYS_COL; gi++) begin : g_col
            logic [DATA_WIDTH-1:0] wr_data_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    wr_data_reg <= '0;
                else if (rd_valid_reg)
                    wr_data_reg <= requant(accum_rd_data[gi*PSUM_W +: PSUM_W], shift_reg);
            end

            assign accum_rd_en[gi]                           = rd_en_reg;
            assign accum_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr_reg;
            assign out_wr_en[gi]                             = wr_en_reg;
            assign out_wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]   = wr_addr_reg;
            assign out_wr_data[gi*DATA_WIDTH +: DATA_WIDTH]   = wr_data_reg;
        end
    endgenerate

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_accum_act_wb.sv
// Directed bench for accum_act_wb: accumulator memory model, write log, immediate-assertion checks.
module tb_accum_act_wb;
    localparam int SYS_COL = 4;
    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int SW      = 5;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b1;
    logic                       start = 1'b0;
    logic [DW-1:0]              num_row = '0;
    logic [AW-1:0]              accum_base_addr = '0;
    logic [AW-1:0]              out_base_addr = '0;
    logic [SW-1:0]              shift = '0;
    logic [SYS_COL-1:0]         accum_rd_en;
    logic [SYS_COL*AW-1:0]      accum_rd_addr;
    logic [SYS_COL*2*DW-1:0]    accum_rd_data = '0;
    logic [SYS_COL-1:0]         out_wr_en;
    logic [SYS_COL*AW-1:0]      out_wr_addr;
    logic [SYS_COL*DW-1:0]      out_wr_data;
    logic                       busy;
    logic                       done;

    accum_act_wb #(.SYS_COL(SYS_COL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_row(num_row),
        .accum_base_addr(accum_base_addr), .out_base_addr(out_base_addr), .shift(shift),
        .accum_rd_en(accum_rd_en), .accum_rd_addr(accum_rd_addr), .accum_rd_data(accum_rd_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [SYS_COL][256];
    logic [15:0] out_mem [SYS_COL][256];

    // Accumulator memory: registered read, data valid the cycle after the enable.
    always @(posedge clk) begin
        for (int c = 0; c < SYS_COL; c++)
            if (accum_rd_en[c])
                accum_rd_data[c*32 +: 32] <= mem[c][accum_rd_addr[c*AW +: AW]];
    end

    int wr_cyc_q[$], wr_addr_q[$], rd_cyc_q[$], rd_addr_q[$], done_cyc_q[$];
    bit busy_at_done_q[$];
    int wr_el_cnt = 0, busy_cnt = 0, col_diff = 0;

    always @(negedge clk) begin
        if (out_wr_en != '0) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(out_wr_addr[AW-1:0]));
            if (out_wr_en != '1) col_diff++;
            for (int c = 0; c < SYS_COL; c++) begin
                if (out_wr_en[c]) begin
                    wr_el_cnt++;
                    out_mem[c][out_wr_addr[c*AW +: AW]] = out_wr_data[c*DW +: DW];
                    if (out_wr_addr[c*AW +: AW] != out_wr_addr[AW-1:0]) col_diff++;
                end
            end
        end
        if (accum_rd_en != '0) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(int'(accum_rd_addr[AW-1:0]));
            if (accum_rd_en != '1) col_diff++;
            for (int c = 0; c < SYS_COL; c++)
                if (accum_rd_addr[c*AW +: AW] != accum_rd_addr[AW-1:0]) col_diff++;
        end
        if (done) begin
            done_cyc_q.push_back(cyc);
            busy_at_done_q.push_back(busy);
        end
        if (busy) busy_cnt++;
    end

    int n_tests = 0, n_fail = 0;
    int s_cyc, w0, r0, d0, e0, b0, w1, d1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int n, input int ab, input int ob, input int sh, input bit repulse);
        w0 = wr_cyc_q.size(); r0 = rd_cyc_q.size(); d0 = done_cyc_q.size();
        e0 = wr_el_cnt; b0 = busy_cnt;
        @(negedge clk);
        num_row = DW'(n); accum_base_addr = AW'(ab); out_base_addr = AW'(ob); shift = SW'(sh);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (repulse) begin
            @(negedge clk);
            num_row = 16'd2; accum_base_addr = 8'd50; out_base_addr = 8'd200; shift = 5'd7;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < n + 20 && done_cyc_q.size() == d0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("done_pulses", 64'(done_cyc_q.size() - d0), 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_sat [2][SYS_COL];

        for (int c = 0; c < SYS_COL; c++)
            for (int r = 0; r < 256; r++)
                mem[c][r] = 32'(10 * r + c);

        #2 rstn = 1'b0;
        #1;
        check("rst_rd_en",   64'(accum_rd_en),   64'd0);
        check("rst_wr_en",   64'(out_wr_en),     64'd0);
        check("rst_busy",    64'(busy),          64'd0);
        check("rst_done",    64'(done),          64'd0);
        check("rst_rd_addr", 64'(accum_rd_addr), 64'd0);
        check("rst_wr_addr", 64'(out_wr_addr),   64'd0);
        check("rst_wr_data", out_wr_data,        64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Basic transfer: N=4, bases 0/0, shift 0
        run_job(4, 0, 0, 0, 1'b0);
        check("basic_rd_rows",  64'(rd_cyc_q.size() - r0), 64'd4);
        check("basic_rd_first", 64'(rd_cyc_q[r0] - s_cyc), 64'd1);
        check("basic_wr_elems", 64'(wr_el_cnt - e0), 64'd16);
        check("basic_wr_first", 64'(wr_cyc_q[w0] - s_cyc), 64'd3);
        check("basic_wr_last",  64'(wr_cyc_q[w0+3] - s_cyc), 64'd6);
        check("basic_done_at",  64'(done_cyc_q[d0] - s_cyc), 64'd7);
        check("basic_busy_at_done", 64'(busy_at_done_q[d0]), 64'd0);
        check("basic_busy_cycles", 64'(busy_cnt - b0), 64'd6);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < SYS_COL; c++)
                check($sformatf("basic_data_r%0d_c%0d", r, c), 64'(out_mem[c][r]), 64'(10 * r + c));

        // Saturation and shift: rows 16 and 17, shift 4
        mem[0][16] = 32'h0010_0000; mem[1][16] = 32'hFFF0_0000;
        mem[2][16] = 32'h0000_0030; mem[3][16] = 32'hFFFF_FFFF;
        mem[0][17] = 32'h0007_FFF0; mem[1][17] = 32'hFFF8_0000;
        mem[2][17] = 32'h0008_0000; mem[3][17] = 32'hFFFF_FFC9;
`ifdef ACCUM_ACT_RELU_EN
        exp_sat[0] = '{16'h7FFF, 16'h0000, 16'h0003, 16'h0000};
        exp_sat[1] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
`else
        exp_sat[0] = '{16'h7FFF, 16'h8000, 16'h0003, 16'hFFFF};
        exp_sat[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFC};
`endif
        run_job(2, 16, 40, 4, 1'b0);
        check("sat_done_at", 64'(done_cyc_q[d0] - s_cyc), 64'd5);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < SYS_COL; c++)
                check($sformatf("sat_data_r%0d_c%0d", r, c), 64'(out_mem[c][40+r]), 64'(exp_sat[r][c]));

        // Address wrap
        run_job(4, 254, 253, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_rd_addr%0d", i), 64'(rd_addr_q[r0+i]), 64'((254 + i) % 256));
            check($sformatf("wrap_wr_addr%0d", i), 64'(wr_addr_q[w0+i]), 64'((253 + i) % 256));
        end
        for (int c = 0; c < SYS_COL; c++) begin
            check($sformatf("wrap_data253_c%0d", c), 64'(out_mem[c][253]), 64'(2540 + c));
            check($sformatf("wrap_data0_c%0d", c),   64'(out_mem[c][0]),   64'(10 + c));
        end

        // N=0
        run_job(0, 5, 5, 0, 1'b0);
        check("n0_rd_rows",  64'(rd_cyc_q.size() - r0), 64'd0);
        check("n0_wr_rows",  64'(wr_cyc_q.size() - w0), 64'd0);
        check("n0_done_at",  64'(done_cyc_q[d0] - s_cyc), 64'd1);
        check("n0_busy_cycles", 64'(busy_cnt - b0), 64'd0);

        // start while busy is ignored
        run_job(4, 0, 100, 0, 1'b1);
        check("rep_rd_rows",  64'(rd_cyc_q.size() - r0), 64'd4);
        check("rep_wr_elems", 64'(wr_el_cnt - e0), 64'd16);
        check("rep_done_at",  64'(done_cyc_q[d0] - s_cyc), 64'd7);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rep_wr_addr%0d", i), 64'(wr_addr_q[w0+i]), 64'(100 + i));
            check($sformatf("rep_data_r%0d", i), 64'(out_mem[3][100+i]), 64'(10 * i + 3));
        end

        // Reset during READ aborts the job
        @(negedge clk);
        num_row = 16'd8; accum_base_addr = 8'd0; out_base_addr = 8'd150; shift = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_rd_en",   64'(accum_rd_en),   64'd0);
        check("abort_wr_en",   64'(out_wr_en),     64'd0);
        check("abort_busy",    64'(busy),          64'd0);
        check("abort_rd_addr", 64'(accum_rd_addr), 64'd0);
        check("abort_wr_data", out_wr_data,        64'd0);
        w1 = wr_cyc_q.size(); d1 = done_cyc_q.size();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_writes", 64'(wr_cyc_q.size() - w1), 64'd0);
        check("abort_no_done",   64'(done_cyc_q.size() - d1), 64'd0);

        run_job(4, 0, 120, 0, 1'b0);
        check("post_wr_elems", 64'(wr_el_cnt - e0), 64'd16);
        check("post_done_at",  64'(done_cyc_q[d0] - s_cyc), 64'd7);
        check("post_data",     64'(out_mem[2][122]), 64'd22);

        check("column_consistency", 64'(col_diff), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
